// File: rtl/divsqrt_seq_pkg.sv
// Shared types for the divide/sqrt sequencer and its result queue.
package divsqrt_seq_pkg;

   // Engine states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } engState_t;

   // Per-result status flags. The tag width is a module parameter, so each
   // module joins a tag of its own width with these flags to form an entry.
   typedef struct packed {
      logic special;
      logic early;
   } resFlags_t;

   // Largest supported result queue depth; queue pointers are sized for it.
   localparam int RESQ_MAX = 4;

endpackage

// File: rtl/divsqrt_resq.sv
// Small result FIFO. Each entry holds a tag and flags. Head fields read as
// zero while the queue is empty. Flush empties the queue.
module divsqrt_resq
   import divsqrt_seq_pkg::*;
#(
   parameter int TAGW = 3,
   parameter int RESQ = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [TAGW-1:0] pushTag,
   input  resFlags_t       pushFlags,
   output logic            headValid,
   output logic [TAGW-1:0] headTag,
   output logic            headSpecial,
   output logic            headEarly,
   output logic [2:0]      occupancy
);

   typedef struct packed {
      logic [TAGW-1:0] tag;
      resFlags_t       flags;
   } resEntry_t;

   localparam logic [1:0] LAST_PTR = 2'(RESQ - 1);

   resEntry_t  mem [RESQ_MAX];
   resEntry_t  headEntry;
   logic [1:0] headPtr;
   logic [1:0] tailPtr;
   logic [2:0] count;
   logic       doPush;
   logic       doPop;

   function automatic logic [1:0] nextPtr(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign doPush = push & ~flush;
   assign doPop  = pop & ~flush & (count != 3'd0);

   // Pointer and count bookkeeping; flush empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         headPtr <= 2'd0;
         tailPtr <= 2'd0;
         count   <= 3'd0;
      end else if (flush) begin
         headPtr <= 2'd0;
         tailPtr <= 2'd0;
         count   <= 3'd0;
      end else begin
         if (doPush) tailPtr <= nextPtr(tailPtr);
         if (doPop)  headPtr <= nextPtr(headPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage. It needs no reset because the count decides validity.
   always_ff @(posedge clk) begin
      if (doPush) mem[tailPtr] <= '{tag: pushTag, flags: pushFlags};
   end

   assign headValid   = (count != 3'd0);
   assign headEntry   = mem[headPtr];
   assign headTag     = headValid ? headEntry.tag : '0;
   assign headSpecial = headValid & headEntry.flags.special;
   assign headEarly   = headValid & headEntry.flags.early;
   assign occupancy   = count;

endmodule

// File: rtl/divsqrt_seq.sv
// Divide/sqrt iteration sequencer.
//
//    state | meaning
//    IDLE  | no op iterating; can accept when a queue slot is free
//    BUSY  | op iterating, iter_en high, step counts down to 1
//
// A special op completes in its accept cycle without entering BUSY. A normal op
// completes when step reaches 1 or the datapath reports a zero residual.
// The sequencer accepts only in IDLE and only when the queue has a free slot.
// A finishing op therefore always has room to push its result.
module divsqrt_seq
   import divsqrt_seq_pkg::*;
#(
   parameter int DURLEN = 7,
   parameter int TAGW   = 3,
   parameter int RESQ   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DURLEN-1:0] cycles,
   input  logic              special,
   input  logic [TAGW-1:0]   tag,
   input  logic              wzero,
   input  logic              stall,
   input  logic              flush,
   output logic              ready,
   output logic              accept,
   output logic              busy,
   output logic              iter_en,
   output logic [DURLEN-1:0] step,
   output logic              done,
   output logic [TAGW-1:0]   done_tag,
   output logic              done_special,
   output logic              done_early,
   output logic [2:0]        occupancy
);

   engState_t         state;
   engState_t         nextState;
   logic [DURLEN-1:0] nextStep;
   logic [TAGW-1:0]   opTag;
   logic              push;
   logic              pop;
   logic [TAGW-1:0]   pushTag;
   resFlags_t         pushFlags;

   // State register, step counter, and the tag captured at accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         step  <= '0;
         opTag <= '0;
      end else begin
         state <= nextState;
         step  <= nextStep;
         if (accept) opTag <= tag;
      end
   end

   // Next-state logic, step update, and result push for the engine.
   always_comb begin
      ready     = (state == IDLE) && (occupancy < 3'(RESQ));
      accept    = start & ready & ~flush;
      busy      = (state == BUSY) | accept;
      iter_en   = (state == BUSY);
      nextState = state;
      nextStep  = step;
      push      = 1'b0;
      pushTag   = tag;
      pushFlags = '{special: 1'b0, early: 1'b0};

      if (flush) begin
         nextState = IDLE;
         nextStep  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (special) begin
                     push      = 1'b1;
                     pushFlags = '{special: 1'b1, early: 1'b0};
                  end else begin
                     nextState = BUSY;
                     nextStep  = (cycles == '0) ? DURLEN'(1) : cycles;
                  end
               end
            end
            BUSY: begin
               pushTag = opTag;
               if ((step == DURLEN'(1)) || wzero) begin
                  push      = 1'b1;
                  pushFlags = '{special: 1'b0, early: wzero && (step != DURLEN'(1))};
                  nextState = IDLE;
               end else begin
                  nextStep = step - DURLEN'(1);
               end
            end
            default: begin
               nextState = IDLE;
               nextStep  = '0;
            end
         endcase
      end
   end

   assign pop = done & ~stall & ~flush;

   divsqrt_resq #(
      .TAGW (TAGW),
      .RESQ (RESQ)
   ) uResq (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .pop         (pop),
      .flush       (flush),
      .pushTag     (pushTag),
      .pushFlags   (pushFlags),
      .headValid   (done),
      .headTag     (done_tag),
      .headSpecial (done_special),
      .headEarly   (done_early),
      .occupancy   (occupancy)
   );

endmodule

// File: tb/tb_divsqrt_seq.sv
// Bench for divsqrt_seq: directed scenarios, then random traffic.
// All outputs are checked every cycle against a queue-based reference model.
module tb_divsqrt_seq;
   localparam int DURLEN = 7;
   localparam int TAGW   = 3;
   localparam int RESQ   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DURLEN-1:0] cycles;
   logic              special;
   logic [TAGW-1:0]   tag;
   logic              wzero;
   logic              stall;
   logic              flush;
   logic              ready;
   logic              accept;
   logic              busy;
   logic              iter_en;
   logic [DURLEN-1:0] step;
   logic              done;
   logic [TAGW-1:0]   done_tag;
   logic              done_special;
   logic              done_early;
   logic [2:0]        occupancy;

   divsqrt_seq #(.DURLEN(DURLEN), .TAGW(TAGW), .RESQ(RESQ)) dut (
      .clk(clk), .reset(reset), .start(start), .cycles(cycles), .special(special),
      .tag(tag), .wzero(wzero), .stall(stall), .flush(flush), .ready(ready),
      .accept(accept), .busy(busy), .iter_en(iter_en), .step(step), .done(done),
      .done_tag(done_tag), .done_special(done_special), .done_early(done_early),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tag;
      bit special;
      bit early;
   } res_t;

   // Reference model: engine busy flag, remaining steps, held tag, result queue
   bit   mBusy;
   int   mStep;
   int   mTag;
   res_t mQ[$];

   int nChecks = 0;
   int nFails  = 0;
   int iterCount;

   task automatic checkEq(input string name, input int obs, input int exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", name, obs, exp, $time);
      end
   endtask

   task automatic setIn(input bit st, input int cyc, input bit sp, input int tg,
                        input bit wz, input bit sl, input bit fl);
      start   = st;
      cycles  = DURLEN'(cyc);
      special = sp;
      tag     = TAGW'(tg);
      wzero   = wz;
      stall   = sl;
      flush   = fl;
   endtask

   task automatic modelReset();
      mBusy = 0;
      mStep = 0;
      mTag  = 0;
      mQ.delete();
   endtask

   task automatic checkResetVals(input string pfx);
      checkEq({pfx, ".ready"}, ready, 1);
      checkEq({pfx, ".busy"}, busy, 0);
      checkEq({pfx, ".iter_en"}, iter_en, 0);
      checkEq({pfx, ".step"}, step, 0);
      checkEq({pfx, ".done"}, done, 0);
      checkEq({pfx, ".done_tag"}, done_tag, 0);
      checkEq({pfx, ".occupancy"}, occupancy, 0);
   endtask

   // Checks all outputs at the falling edge, then advances the model to the next rising edge.
   task automatic stepCycle();
      bit   mReady;
      bit   mAccept;
      bit   pushIt;
      res_t item;
      @(negedge clk);
      mReady  = !mBusy && (mQ.size() < RESQ);
      mAccept = start && mReady && !flush;
      checkEq("ready", ready, mReady);
      checkEq("accept", accept, mAccept);
      checkEq("busy", busy, mBusy || mAccept);
      checkEq("iter_en", iter_en, mBusy);
      checkEq("step", step, mStep);
      checkEq("occupancy", occupancy, mQ.size());
      checkEq("done", done, mQ.size() > 0);
      if (mQ.size() > 0) begin
         checkEq("done_tag", done_tag, mQ[0].tag);
         checkEq("done_special", done_special, mQ[0].special);
         checkEq("done_early", done_early, mQ[0].early);
      end
      if (iter_en) iterCount++;

      pushIt = 0;
      item   = '{tag: 0, special: 0, early: 0};
      if (flush) begin
         modelReset();
      end else begin
         if (mAccept) begin
            mTag = int'(tag);
            if (special) begin
               pushIt = 1;
               item   = '{tag: int'(tag), special: 1, early: 0};
            end else begin
               mBusy = 1;
               mStep = (cycles == 0) ? 1 : int'(cycles);
            end
         end else if (mBusy) begin
            if (mStep == 1 || wzero) begin
               pushIt = 1;
               item   = '{tag: mTag, special: 0, early: wzero && (mStep != 1)};
               mBusy  = 0;
            end else begin
               mStep--;
            end
         end
         if (mQ.size() > 0 && !stall) void'(mQ.pop_front());
         if (pushIt) mQ.push_back(item);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         setIn(0, 0, 0, 0, 0, 0, 0);
         stepCycle();
      end
   endtask

   initial begin
      reset = 1'b1;
      setIn(0, 0, 0, 0, 0, 0, 0);
      modelReset();
      #12;
      checkResetVals("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Five-step op: five iterate cycles, then the result with tag 3
      iterCount = 0;
      setIn(1, 5, 0, 3, 0, 0, 0);
      stepCycle();
      idle(8);
      checkEq("five_step_iters", iterCount, 5);

      // Special op completes without iterating
      iterCount = 0;
      setIn(1, 9, 1, 6, 0, 0, 0);
      stepCycle();
      idle(3);
      checkEq("special_iters", iterCount, 0);

      // Ten-step op terminated early by wzero in the 4th busy cycle
      iterCount = 0;
      setIn(1, 10, 0, 1, 0, 0, 0);
      stepCycle();
      for (int i = 1; i <= 4; i++) begin
         setIn(0, 0, 0, 0, i == 4, 0, 0);
         stepCycle();
      end
      idle(4);
      checkEq("early_iters", iterCount, 4);

      // Queue fills under stall and blocks further accepts; releasing stall drains it in order
      for (int i = 0; i < 12; i++) begin
         setIn(1, 2, 0, i % 8, 0, 1, 0);
         stepCycle();
      end
      checkEq("stall_full_occ", occupancy, RESQ);
      for (int i = 0; i < 6; i++) begin
         setIn(1, 2, 0, 5, 0, 0, 0);
         stepCycle();
      end
      idle(6);

      // Flush in the 3rd busy cycle while one result is waiting in the queue
      setIn(1, 0, 1, 2, 0, 1, 0);
      stepCycle();
      setIn(1, 6, 0, 4, 0, 1, 0);
      stepCycle();
      for (int i = 1; i <= 3; i++) begin
         setIn(0, 0, 0, 0, 0, 1, i == 3);
         stepCycle();
      end
      checkEq("flush_done", done, 0);
      checkEq("flush_ready", ready, 1);
      idle(2);

      // A zero cycle count runs for one busy cycle
      iterCount = 0;
      setIn(1, 0, 0, 7, 0, 0, 0);
      stepCycle();
      idle(3);
      checkEq("zero_cycles_iters", iterCount, 1);

      // Asynchronous reset while busy clears outputs without a clock edge
      setIn(1, 8, 0, 5, 0, 0, 0);
      stepCycle();
      idle(2);
      #2;
      reset = 1'b1;
      #1;
      checkResetVals("async_reset");
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         setIn($urandom % 3 == 0, $urandom_range(0, 9), $urandom % 5 == 0,
               $urandom_range(0, 7), $urandom % 8 == 0, $urandom % 3 == 0,
               $urandom % 50 == 0);
         stepCycle();
      end
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
